// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Purpose:
//   Parallel-to-serial converter. The source deposits a WIDTH-bit word into a
//   one-word holding register. A shift engine then emits it MSB first, one bit
//   per clock. When the holding register is refilled before the last bit of
//   the current word, the next word follows with no idle cycle.
//
// Handshake:
//   A word is accepted at a rising edge where in_valid=1 and in_ready=1.
//   in_ready is a plain register decode (!hold_full), so nothing
//   combinational runs from in_valid/in_data to in_ready. The source must hold
//   in_valid and in_data stable until the accepting edge. There is no
//   backpressure on the serial side: d_valid qualifies d_out cycle by cycle.
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   clr         in   synchronous abort; drops held and in-flight data
//   in_valid    in   source presents a word
//   in_data     in   [WIDTH-1:0] parallel word, captured on accept
//   in_ready    out  holding register empty
//   d_out       out  registered serial bit (0 whenever d_valid=0)
//   d_valid     out  registered qualifier for d_out
//   busy        out  engine not IDLE or holding register full
//   o_dbg_state out  [1:0] current engine state (0=IDLE, 1=SHIFT, 2=PAR)
//
// Build option:
//   BIT_SERIALIZER_PARITY_EN - when defined, each word is followed by one
//   even-parity bit (XOR of the word) in a PAR state, so each word takes
//   WIDTH+1 cycles. When undefined, there is no PAR state and no parity logic.
// -----------------------------------------------------------------------------
module bit_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             d_out,
   output logic             d_valid,
   output logic             busy,
   output logic [1:0]       o_dbg_state
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1
`ifdef BIT_SERIALIZER_PARITY_EN
      ,
      PAR   = 2'd2
`endif
   } state_t;

   // Registered state
   state_t             r_state;
   logic [WIDTH-1:0]   r_hold;
   logic               r_hold_full;
   logic [WIDTH-1:0]   r_shreg;
   logic [CNT_W-1:0]   r_bit_cnt;
   logic               r_d_out;
   logic               r_d_valid;
`ifdef BIT_SERIALIZER_PARITY_EN
   logic               r_parity;
   logic               w_parity_nxt;
`endif

   // Next-state values
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   w_hold_nxt;
   logic               w_hold_full_nxt;
   logic [WIDTH-1:0]   w_shreg_nxt;
   logic [CNT_W-1:0]   w_bit_cnt_nxt;
   logic               w_d_out_nxt;
   logic               w_d_valid_nxt;
   logic               w_accept;
   logic               w_load;
   logic [WIDTH-1:0]   w_shreg_shl;

   // Accept only needs an empty hold; load only fires with a full hold,
   // so the two never happen in the same cycle.
   assign w_accept    = in_valid && !r_hold_full;
   // r_shreg keeps the bit now on d_out in its MSB. Shifting left brings
   // the next bit to the MSB position.
   assign w_shreg_shl = r_shreg << 1;

   // -------------------------------------------------------------------------
   // Next-state / output logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt     = r_state;
      w_hold_nxt      = r_hold;
      w_hold_full_nxt = r_hold_full;
      w_shreg_nxt     = r_shreg;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_d_out_nxt     = 1'b0;
      w_d_valid_nxt   = 1'b0;
      w_load          = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      w_parity_nxt    = r_parity;
`endif

      if (w_accept) begin
         w_hold_nxt      = in_data;
         w_hold_full_nxt = 1'b1;
      end

      case (r_state)
         IDLE: begin
            w_load = r_hold_full;
         end
         SHIFT: begin
            if (r_bit_cnt != LAST_BIT) begin
               w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
               w_shreg_nxt   = w_shreg_shl;
               w_d_out_nxt   = w_shreg_shl[WIDTH-1];
               w_d_valid_nxt = 1'b1;
            end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
               w_state_nxt   = PAR;
               w_d_out_nxt   = r_parity;
               w_d_valid_nxt = 1'b1;
`else
               // Last data bit ends here: chain straight into the next word
               // if one is waiting, otherwise go idle.
               w_load = r_hold_full;
               if (!r_hold_full) begin
                  w_state_nxt = IDLE;
               end
`endif
            end
         end
`ifdef BIT_SERIALIZER_PARITY_EN
         PAR: begin
            w_load = r_hold_full;
            if (!r_hold_full) begin
               w_state_nxt = IDLE;
            end
         end
`endif
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      if (w_load) begin
         w_state_nxt     = SHIFT;
         w_shreg_nxt     = r_hold;
         w_bit_cnt_nxt   = '0;
         w_d_out_nxt     = r_hold[WIDTH-1];
         w_d_valid_nxt   = 1'b1;
         w_hold_full_nxt = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
         w_parity_nxt    = ^r_hold;
`endif
      end

      // Abort wins over everything above, including a same-cycle accept.
      if (clr) begin
         w_state_nxt     = IDLE;
         w_hold_full_nxt = 1'b0;
         w_bit_cnt_nxt   = '0;
         w_d_out_nxt     = 1'b0;
         w_d_valid_nxt   = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_shreg     <= '0;
         r_bit_cnt   <= '0;
         r_d_out     <= 1'b0;
         r_d_valid   <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
         r_parity    <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_hold      <= w_hold_nxt;
         r_hold_full <= w_hold_full_nxt;
         r_shreg     <= w_shreg_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_d_out     <= w_d_out_nxt;
         r_d_valid   <= w_d_valid_nxt;
`ifdef BIT_SERIALIZER_PARITY_EN
         r_parity    <= w_parity_nxt;
`endif
      end
   end

   assign in_ready    = !r_hold_full;
   assign d_out       = r_d_out;
   assign d_valid     = r_d_valid;
   assign busy        = (r_state != IDLE) || r_hold_full;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//
// Directed bench for bit_serializer (WIDTH=8). Expected serial bits are queued
// MSB first whenever a word is offered. Every step samples the outputs 1 ns
// after the rising edge: a valid bit pops the queue and is compared, and an
// invalid cycle must show d_out=0. When BIT_SERIALIZER_PARITY_EN is defined,
// the queued stream also includes the even-parity bit of each word.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

   localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif

   // ---------------- clock / reset ----------------
   logic         clk;
   logic         reset_n;
   logic         clr;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic         d_out;
   logic         d_valid;
   logic         busy;
   logic [1:0]   dbg_state;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   bit_serializer #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .clr         (clr),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .d_out       (d_out),
      .d_valid     (d_valid),
      .busy        (busy),
      .o_dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef BIT_SERIALIZER_PARITY_EN
      exp_q.push_back(^w);
`endif
   endtask

   // One clock: advance past the edge, then compare the serial output.
   task automatic step();
      logic e;
      @(posedge clk);
      #1;
      if (d_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("extra_bit", d_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("d_out", d_out, e);
         end
      end else begin
         check("d_out_idle", d_out, 1'b0);
      end
   endtask

   // Run until the expected queue empties, bounded by max_cyc.
   task automatic drain(input int max_cyc, output int n_valid);
      int i;
      n_valid = 0;
      i = 0;
      while (exp_q.size() != 0 && i < max_cyc) begin
         step();
         if (d_valid === 1'b1) n_valid++;
         i++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   // Every one of n cycles must carry a stream bit.
   task automatic expect_stream(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         check("gapless", d_valid, 1'b1);
      end
   endtask

   // Offer one word to an idle engine and follow it to completion.
   task automatic send_single(input logic [W-1:0] w);
      int nv;
      in_valid = 1'b1;
      in_data  = w;
      push_word(w);
      step();                                // E0: accept
      check("ready_after_accept", in_ready, 1'b0);
      check("busy_after_accept", busy, 1'b1);
      in_valid = 1'b0;
      step();                                // E1: load, MSB valid
      check("latency_valid", d_valid, 1'b1);
      check("ready_after_load", in_ready, 1'b1);
      drain(40, nv);
      check("word_cycles", nv + 1, NB);
      step();
      check("idle_valid", d_valid, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_state", dbg_state, 2'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int nv;
      int n;
      reset_n  = 1'b0;
      clr      = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;

      // Reset state
      #12;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_d_valid", d_valid, 1'b0);
      check("rst_d_out", d_out, 1'b0);
      check("rst_state", dbg_state, 2'd0);
      reset_n = 1'b1;
      step();
      step();

      // Single word 5A
      send_single(8'h5A);

      // Parity-specific words (also valid without parity)
      send_single(8'h07);

      // Back-to-back 05 then A0
      in_valid = 1'b1;
      in_data  = 8'h05;
      push_word(8'h05);
      step();                                // E0 accept 05
      in_data  = 8'hA0;
      push_word(8'hA0);
      step();                                // E1 load 05
      check("b2b_ready_e1", in_ready, 1'b1);
      check("b2b_valid_e1", d_valid, 1'b1);
      step();                                // E2 accept A0
      check("b2b_ready_e2", in_ready, 1'b0);
      in_valid = 1'b0;
      expect_stream(2 * NB - 2);
      check("b2b_queue_empty", exp_q.size(), 0);
      check("b2b_ready_end", in_ready, 1'b1);
      step();
      check("b2b_idle", d_valid, 1'b0);

      // Backpressure: hold full during SHIFT with in_data wandering
      in_valid = 1'b1;
      in_data  = 8'h3C;
      push_word(8'h3C);
      step();                                // accept 3C
      step();                                // load 3C
      in_data  = 8'hC3;
      push_word(8'hC3);
      step();                                // accept C3
      check("bp_ready_full", in_ready, 1'b0);
      for (int i = 0; i < NB - 2; i++) begin
         in_data = W'($urandom_range(0, 255));
         step();
         check("bp_ready_low", in_ready, 1'b0);
      end
      in_data = W'($urandom_range(0, 255));
      step();                                // load C3
      check("bp_ready_after_load", in_ready, 1'b1);
      in_valid = 1'b0;
      drain(40, nv);
      step();
      check("bp_idle", busy, 1'b0);

      // Abort during bit 3 of FF, with a competing accept
      in_valid = 1'b1;
      in_data  = 8'hFF;
      push_word(8'hFF);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();   // bits 0..3
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h55;
      exp_q.delete();
      step();
      check("clr_d_valid", d_valid, 1'b0);
      check("clr_busy", busy, 1'b0);
      check("clr_in_ready", in_ready, 1'b1);
      clr      = 1'b0;
      in_valid = 1'b0;
      step();
      check("clr_no_resume", d_valid, 1'b0);
      check("clr_no_accept", busy, 1'b0);

      // Asynchronous reset mid-word of A5
      in_valid = 1'b1;
      in_data  = 8'hA5;
      push_word(8'hA5);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();   // bits 1,0,1 out
      check("pre_rst_d_out", d_out, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_d_out", d_out, 1'b0);
      check("arst_d_valid", d_valid, 1'b0);
      check("arst_in_ready", in_ready, 1'b1);
      check("arst_busy", busy, 1'b0);
      exp_q.delete();
      #1;
      reset_n = 1'b1;
      step();
      step();
      check("arst_no_resume", d_valid, 1'b0);
      send_single(8'h81);

      // Random words with random idle gaps between offers
      for (int k = 0; k < 6; k++) begin
         logic [W-1:0] w;
         w        = W'($urandom_range(0, 255));
         in_valid = 1'b1;
         in_data  = w;
         push_word(w);
         n = 0;
         while (in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
         end
         check("rnd_accept_wait", in_ready, 1'b1);
         step();                             // accept
         in_valid = 1'b0;
         n = $urandom_range(0, 3);
         for (int g = 0; g < n; g++) step();
      end
      drain(200, nv);
      step();
      check("rnd_idle", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
